port_out_scheduler: RTL
=======================

# port_out_scheduler

Per-output-port read scheduler. It sits between the cache manager's per-priority queue heads and the shared packet SRAM read port. Each cycle it picks one ready, prepared priority queue by strict priority or by weighted round-robin, dequeues its head packet and reads the packet's words from SRAM in order. It drives the port's rd_sop/rd_eop/rd_vld/rd_data stream. One instance exists per output port, 16 in the top level.

## Interface
- num_of_priority, 8, number of priority queues per port
- priority_width, 3, width of a priority index
- data_width, 64, SRAM word and rd_data width
- address_width, 12, SRAM word address width
- des_port_width, 7, packet-length field width (words)
- wrr_weight_width, 4, per-queue WRR weight width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- sp0_wrr1  in  1  0 = strict priority, 1 = WRR; sampled at grant decisions only
- ready  in  num_of_priority  downstream accepts packets of priority p
- prepared  in  num_of_priority  queue p holds at least one complete packet
- head_addr  in  num_of_priority*address_width  first-word address of queue p head packet; slice p = [p*address_width +: address_width]
- head_len  in  num_of_priority*des_port_width  head packet length in words; 0 is treated as 1
- wrr_weight  in  num_of_priority*wrr_weight_width  packets per WRR round for queue p; 0 is treated as 1
- pop  out  num_of_priority  one-hot, 1-cycle dequeue pulse to the cache manager
- rd_request  out  1  SRAM read enable
- rd_addr  out  address_width  SRAM read address
- sram_data  in  data_width  SRAM read data, valid 1 cycle after rd_request
- rd_sop, rd_eop, rd_vld  out  1  output packet framing
- rd_data  out  data_width  output packet word
- rd_priority  out  priority_width  priority of the packet currently being read
- busy  out  1  high while in READ

## Operation
- Eligible vector: elig = prepared & ready.
- States:
  - IDLE → READ on a grant.
  - READ → IDLE at the last word with no grant.
  - READ → READ at the last word when there is a new grant, giving back-to-back packets.
- Grants happen only in IDLE, or in the final read cycle of READ. A packet is never interrupted; ready matters only at grant time.
- Strict priority: grant the highest eligible index (7 is highest).
- WRR:
  - Per-queue credit counters plus a round-robin pointer rr_ptr.
  - Search from rr_ptr upward, wrapping, for the first eligible queue with credit > 0.
  - On grant, credit decrements by 1.
  - If the credit reaches 0, rr_ptr moves to the granted index + 1 (mod 8). Otherwise rr_ptr stays on the granted index.
  - If elig ≠ 0 but no eligible queue has credit: reload all credits from the weights that cycle with no grant. The grant follows in the next cycle.
- Grant cycle actions:
  - pop[p] = 1.
  - Latch base = head_addr[p], len = head_len[p] (0 → 1), rd_priority = p.
- Read sequence: rd_request = 1 for len consecutive cycles, with rd_addr = base + i for i = 0..len−1. The address wraps modulo 2^address_width.
- Output stage: a 2-stage valid/sop/eop pipeline aligned with sram_data. rd_data is registered from sram_data.
- Cache-manager contract: prepared, head_addr and head_len reflect a pop from the cycle after the pop.
- Reset values:
  - All outputs 0; state IDLE.
  - Credits 0, so the first WRR decision reloads. rr_ptr = 0.
  - Pipeline valid bits cleared, so in-flight words are discarded.
- Reset mid-packet: output stops the next cycle. No rd_eop is emitted for the truncated packet.
- A change of sp0_wrr1 mid-packet has no effect until the next grant. WRR credits are kept across mode changes.

## Timing
- Grant at cycle G:
  - pop at G.
  - rd_request/rd_addr at G+1 … G+L.
  - rd_vld at G+3 … G+L+2.
  - rd_sop at G+3; rd_eop at G+L+2.
- 1-word packet: rd_sop and rd_eop are both high at G+3.
- Back-to-back grant at G+L gives continuous rd_request with no bubble.
- busy is high G+1 … G+L.
- Throughput: 1 word/cycle. The only bubbles are the WRR reload cycle and IDLE gaps.

## Test plan
- SP arbitration: prepared = ready = 0x81, len[7] = 3 at addr 0x010, len[0] = 2 at addr 0x100, sp0_wrr1 = 0.
  - pop = 0x80, rd_addr 0x010, 0x011, 0x012.
  - pop = 0x01 at the last read cycle, then rd_addr 0x100, 0x101 with no gap.
  - rd_sop/rd_eop frame 3 words then 2 words.
- WRR weights: weights q0 = 2, q1 = 1, both always eligible, 1-word packets.
  - Grant order: reload bubble, then q0, q0, q1, reload bubble, then q0, q0, q1.
- Address wrap: base 0xFFE, len 4 → rd_addr 0xFFE, 0xFFF, 0x000, 0x001.
- Ready gating and non-preemption:
  - ready[5] = 0 with prepared[5] = 1 → no pop[5].
  - Raise ready[6] mid-packet on q3 → the q3 packet completes before q6 is granted.
- Reset during an 8-word packet at read word 4:
  - Next cycle: rd_vld = 0, busy = 0, pop = 0, no rd_eop.
  - Subsequent grant restarts cleanly.
- Length 0 and 1: head_len = 0 and head_len = 1 each produce one word with rd_sop = rd_eop = 1, three cycles after the pop.

Source files
------------

// File: rtl/port_out_scheduler.sv
// Per-output-port read scheduler: picks a priority queue by strict priority or WRR,
// pops its head packet and streams the packet's words out of the shared SRAM.
module port_out_scheduler #(
    parameter int num_of_priority  = 8,
    parameter int priority_width   = 3,
    parameter int data_width       = 64,
    parameter int address_width    = 12,
    parameter int des_port_width   = 7,
    parameter int wrr_weight_width = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         sp0_wrr1,
    input  logic [num_of_priority-1:0]                   ready,
    input  logic [num_of_priority-1:0]                   prepared,
    input  logic [num_of_priority*address_width-1:0]     head_addr,
    input  logic [num_of_priority*des_port_width-1:0]    head_len,
    input  logic [num_of_priority*wrr_weight_width-1:0]  wrr_weight,
    output logic [num_of_priority-1:0]                   pop,
    output logic                                         rd_request,
    output logic [address_width-1:0]                     rd_addr,
    input  logic [data_width-1:0]                        sram_data,
    output logic                                         rd_sop,
    output logic                                         rd_eop,
    output logic                                         rd_vld,
    output logic [data_width-1:0]                        rd_data,
    output logic [priority_width-1:0]                    rd_priority,
    output logic                                         busy
);

    typedef enum logic {IDLE, READ} state_t;

    localparam logic [des_port_width-1:0]   len_one    = 1;
    localparam logic [wrr_weight_width-1:0] credit_one = 1;

    state_t                        state, state_next;
    logic [address_width-1:0]      base;
    logic [des_port_width-1:0]     len, cnt;
    logic [num_of_priority-1:0]    elig;
    logic                          last, window;
    logic                          grant, reload, found;
    logic [priority_width-1:0]     grant_idx, idx;
    logic [priority_width-1:0]     rr_ptr;
    logic [wrr_weight_width-1:0]   credit [num_of_priority];
    logic [address_width-1:0]      sel_addr;
    logic [des_port_width-1:0]     sel_len;
    logic                          v1, s1, e1;

    assign elig   = prepared & ready;
    assign busy   = (state == READ);
    assign last   = busy && (cnt == len - len_one);
    assign window = (state == IDLE) || last;

    assign rd_request = busy;
    assign rd_addr    = busy ? base + address_width'(cnt) : '0;

    assign sel_addr = head_addr[int'(grant_idx)*address_width +: address_width];
    assign sel_len  = head_len[int'(grant_idx)*des_port_width +: des_port_width];

    // Grant decision; a WRR search that finds no credit turns into a reload cycle.
    always_comb begin
        grant     = 1'b0;
        reload    = 1'b0;
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        if (window && !rst && (elig != '0)) begin
            if (!sp0_wrr1) begin
                for (int i = 0; i < num_of_priority; i++) begin
                    if (elig[i]) begin
                        grant     = 1'b1;
                        grant_idx = priority_width'(i);
                    end
                end
            end else begin
                for (int i = 0; i < num_of_priority; i++) begin
                    idx = rr_ptr + priority_width'(i);
                    if (!found && elig[idx] && (credit[idx] != '0)) begin
                        found     = 1'b1;
                        grant_idx = idx;
                    end
                end
                grant  = found;
                reload = !found;
            end
        end
    end

    always_comb begin
        pop        = '0;
        state_next = state;
        if (grant) begin
            pop[grant_idx] = 1'b1;
        end
        case (state)
            IDLE:    if (grant) state_next = READ;
            READ:    if (last) state_next = grant ? READ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            cnt         <= '0;
            rd_priority <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                base        <= sel_addr;
                len         <= (sel_len == '0) ? len_one : sel_len;
                cnt         <= '0;
                rd_priority <= grant_idx;
            end else if (busy) begin
                cnt <= cnt + len_one;
            end
        end
    end

    // Credits survive SP operation so a return to WRR resumes the current round.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < num_of_priority; i++) begin
                credit[i] <= '0;
            end
        end else if (reload) begin
            for (int i = 0; i < num_of_priority; i++) begin
                credit[i] <= (wrr_weight[i*wrr_weight_width +: wrr_weight_width] == '0) ?
                             credit_one : wrr_weight[i*wrr_weight_width +: wrr_weight_width];
            end
        end else if (grant && sp0_wrr1) begin
            credit[grant_idx] <= credit[grant_idx] - credit_one;
            rr_ptr <= (credit[grant_idx] == credit_one) ? grant_idx + priority_width'(1) : grant_idx;
        end
    end

    // Stage 1 lines up with sram_data, stage 2 registers the word onto the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1      <= 1'b0;
            e1      <= 1'b0;
            rd_vld  <= 1'b0;
            rd_sop  <= 1'b0;
            rd_eop  <= 1'b0;
            rd_data <= '0;
        end else begin
            v1      <= busy;
            s1      <= busy && (cnt == '0);
            e1      <= last;
            rd_vld  <= v1;
            rd_sop  <= s1;
            rd_eop  <= e1;
            rd_data <= v1 ? sram_data : '0;
        end
    end

endmodule
